// File: rtl/dma_read_checker.sv
// dma_read_checker: issues cfg_ops read commands on DMA channel 1 and checks
// each returned beat against the counter pattern (in-op beat index + offset).
// Optional feature macro: DMA_RD_FULL_CMP_EN compares all DATA_W bits (upper
// bits must be zero); when undefined only data[31:0] is compared.
module dma_read_checker #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              user_clk,
  input  logic              user_aresetn,
  input  logic              start,
  input  logic [63:0]       cfg_addr,
  input  logic [31:0]       cfg_length,
  input  logic [31:0]       cfg_offset,
  input  logic [31:0]       cfg_ops,
  output logic              m_rd_cmd_valid,
  input  logic              m_rd_cmd_ready,
  output logic [63:0]       m_rd_cmd_address,
  output logic [31:0]       m_rd_cmd_length,
  input  logic              s_rd_data_valid,
  output logic              s_rd_data_ready,
  input  logic [DATA_W-1:0] s_rd_data_data,
  input  logic              s_rd_data_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stray_cnt
);

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned LEN_W  = 32;
  localparam int unsigned IDX_W  = 32;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_CMD, S_DATA, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                start_r_q, start_rr_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    off_q, off_d;
  logic [LEN_W-1:0]    ops_q, ops_d;
  logic [LEN_W-1:0]    bpo_q, bpo_d;
  logic [IDX_W-1:0]    op_idx_q, op_idx_d;
  logic [IDX_W-1:0]    w_q, w_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]    first_err_q, first_err_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]    stray_cnt_q, stray_cnt_d;

  logic                launch_c;
  logic [IDX_W-1:0]    exp_c;
  logic                mismatch_c;
  logic                final_c;
  logic                beat_err_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign launch_c = start_r_q & ~start_rr_q;
  assign exp_c    = w_q + off_q;
  assign final_c  = (w_q == (bpo_q - IDX_W'(1)));

`ifdef DMA_RD_FULL_CMP_EN
  assign mismatch_c = (s_rd_data_data != DATA_W'(exp_c));
`else
  logic unused_upper_c;
  assign unused_upper_c = ^s_rd_data_data[DATA_W-1:32];
  assign mismatch_c     = (s_rd_data_data[31:0] != exp_c);
`endif

  // Counted once per beat whatever combination of faults it carries.
  assign beat_err_c = mismatch_c | (s_rd_data_last != final_c);

  // Next-state, command sequencing and status counter updates.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    off_d       = off_q;
    ops_d       = ops_q;
    bpo_d       = bpo_q;
    op_idx_d    = op_idx_q;
    w_d         = w_q;
    done_d      = done_q;
    cfg_err_d   = cfg_err_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    beat_cnt_d  = beat_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    stray_cnt_d = stray_cnt_q;

    if (state_q == S_CMD || state_q == S_DATA) begin
      cycle_cnt_d = sat_inc(cycle_cnt_q);
    end
    if (s_rd_data_valid && state_q != S_DATA) begin
      stray_cnt_d = sat_inc(stray_cnt_q);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (launch_c) begin
          state_d     = S_CHECK;
          addr_d      = cfg_addr;
          len_d       = cfg_length;
          off_d       = cfg_offset;
          ops_d       = (cfg_ops == '0) ? LEN_W'(1) : cfg_ops;
          bpo_d       = cfg_length >> 6;
          op_idx_d    = '0;
          w_d         = '0;
          done_d      = 1'b0;
          cfg_err_d   = 1'b0;
          err_cnt_d   = '0;
          first_err_d = '0;
          beat_cnt_d  = '0;
          cycle_cnt_d = '0;
          stray_cnt_d = '0;
        end
      end
      S_CHECK: begin
        if (len_q == '0 || len_q[5:0] != 6'd0) begin
          state_d   = S_DONE;
          cfg_err_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (m_rd_cmd_ready) begin
          state_d = S_DATA;
          w_d     = '0;
        end
      end
      S_DATA: begin
        if (s_rd_data_valid) begin
          beat_cnt_d = sat_inc(beat_cnt_q);
          if (beat_err_c) begin
            if (err_cnt_q == '0) begin
              first_err_d = beat_cnt_q;
            end
            err_cnt_d = sat_inc(err_cnt_q);
          end
          if (final_c) begin
            op_idx_d = op_idx_q + IDX_W'(1);
            if (op_idx_q == ops_q - IDX_W'(1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_CMD;
              addr_d  = addr_q + ADDR_W'(len_q);
            end
          end else begin
            w_d = w_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_valid_d = (state_d == S_CMD);
    busy_d      = (state_d == S_CHECK) || (state_d == S_CMD) || (state_d == S_DATA);
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge user_clk) begin
    if (!user_aresetn) begin
      state_q     <= S_IDLE;
      start_r_q   <= 1'b0;
      start_rr_q  <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      off_q       <= '0;
      ops_q       <= '0;
      bpo_q       <= '0;
      op_idx_q    <= '0;
      w_q         <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      beat_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      stray_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      start_r_q   <= start;
      start_rr_q  <= start_r_q;
      addr_q      <= addr_d;
      len_q       <= len_d;
      off_q       <= off_d;
      ops_q       <= ops_d;
      bpo_q       <= bpo_d;
      op_idx_q    <= op_idx_d;
      w_q         <= w_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      beat_cnt_q  <= beat_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      stray_cnt_q <= stray_cnt_d;
    end
  end

  assign m_rd_cmd_valid   = cmd_valid_q;
  assign m_rd_cmd_address = addr_q;
  assign m_rd_cmd_length  = len_q;
  assign s_rd_data_ready  = 1'b1;
  assign busy             = busy_q;
  assign done             = done_q;
  assign cfg_err          = cfg_err_q;
  assign err_cnt          = err_cnt_q;
  assign first_err_idx    = first_err_q;
  assign beat_cnt         = beat_cnt_q;
  assign cycle_cnt        = cycle_cnt_q;
  assign stray_cnt        = stray_cnt_q;

endmodule

// File: tb/tb_dma_read_checker.sv
// Directed bench for dma_read_checker: acts as the DMA engine's command sink
// and read-data source. Honours DMA_RD_FULL_CMP_EN for the wide-compare case.
module tb_dma_read_checker;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [63:0]  cfg_addr;
  logic [31:0]  cfg_length, cfg_offset, cfg_ops;
  logic         cmd_valid, cmd_ready;
  logic [63:0]  cmd_addr;
  logic [31:0]  cmd_len;
  logic         rd_valid, rd_ready, rd_last;
  logic [511:0] rd_data;
  logic         busy, done, cfg_err;
  logic [31:0]  err_cnt, first_err_idx, beat_cnt, cycle_cnt, stray_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  dma_read_checker dut (
    .user_clk(clk), .user_aresetn(rstn), .start(start),
    .cfg_addr(cfg_addr), .cfg_length(cfg_length), .cfg_offset(cfg_offset), .cfg_ops(cfg_ops),
    .m_rd_cmd_valid(cmd_valid), .m_rd_cmd_ready(cmd_ready),
    .m_rd_cmd_address(cmd_addr), .m_rd_cmd_length(cmd_len),
    .s_rd_data_valid(rd_valid), .s_rd_data_ready(rd_ready),
    .s_rd_data_data(rd_data), .s_rd_data_last(rd_last),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx), .beat_cnt(beat_cnt),
    .cycle_cnt(cycle_cnt), .stray_cnt(stray_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int w, input logic [31:0] off);
    logic [511:0] d;
    d = '0;
    d[31:0] = 32'(w) + off;
    return d;
  endfunction

  task automatic do_reset();
    rstn = 1'b0; start = 1'b0; cmd_ready = 1'b0;
    rd_valid = 1'b0; rd_last = 1'b0; rd_data = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic launch(input logic [63:0] a, input logic [31:0] l,
                        input logic [31:0] o, input logic [31:0] n);
    cfg_addr = a; cfg_length = l; cfg_offset = o; cfg_ops = n;
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
  endtask

  task automatic take_cmd(input string tag, input logic [63:0] ea,
                          input logic [31:0] el, input int hold);
    int t;
    t = 0;
    while (cmd_valid !== 1'b1 && t < 50) begin tick(); t++; end
    chk({tag, "_valid"}, 128'(cmd_valid), 128'(1));
    chk({tag, "_addr"}, 128'(cmd_addr), 128'(ea));
    chk({tag, "_len"}, 128'(cmd_len), 128'(el));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_stable"}, 128'({cmd_valid, cmd_addr, cmd_len}), 128'({1'b1, ea, el}));
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic send_beat(input logic [511:0] d, input logic last);
    rd_valid = 1'b1; rd_data = d; rd_last = last;
    tick();
    rd_valid = 1'b0; rd_last = 1'b0;
  endtask

  task automatic send_op(input int nb, input logic [31:0] off);
    for (int b = 0; b < nb; b++) send_beat(pat(b, off), b == nb - 1);
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 200) begin tick(); t++; end
    chk(tag, 128'(done), 128'(1));
  endtask

  initial begin
    logic [511:0] d;
    logic         seen;
    int           exp_wide;

    // Reset state
    cfg_addr = '0; cfg_length = '0; cfg_offset = '0; cfg_ops = '0;
    do_reset();
    chk("rst_outs", 128'({cmd_valid, busy, done, cfg_err, rd_ready}), 128'(5'b00001));
    chk("rst_cnts", 128'({err_cnt, beat_cnt, cycle_cnt, stray_cnt}), 128'(0));

    // 1: single 4 KiB command, ideal data
    launch(64'h0000_0000_0000_A000, 32'd4096, 32'h100, 32'd1);
    take_cmd("t1_cmd", 64'h0000_0000_0000_A000, 32'd4096, 0);
    send_op(64, 32'h100);
    wait_done("t1_done");
    chk("t1_beats", 128'(beat_cnt), 128'(64));
    chk("t1_err", 128'(err_cnt), 128'(0));
    chk("t1_busy", 128'(busy), 128'(0));
    chk("t1_cycles", 128'(cycle_cnt), 128'(65));

    // 2: three commands, backpressure on the second
    launch(64'h1000, 32'd128, 32'd0, 32'd3);
    take_cmd("t2_c0", 64'h1000, 32'd128, 0);
    send_op(2, 32'd0);
    chk("t2_next_valid", 128'(cmd_valid), 128'(1));
    take_cmd("t2_c1", 64'h1080, 32'd128, 5);
    send_op(2, 32'd0);
    take_cmd("t2_c2", 64'h1100, 32'd128, 0);
    send_op(2, 32'd0);
    wait_done("t2_done");
    chk("t2_beats", 128'(beat_cnt), 128'(6));
    chk("t2_err", 128'(err_cnt), 128'(0));

    // 3a: corrupt low word of beat 10
    launch(64'h2000, 32'd1024, 32'd0, 32'd1);
    take_cmd("t3a_cmd", 64'h2000, 32'd1024, 0);
    for (int b = 0; b < 16; b++) begin
      d = pat(b, 32'd0);
      if (b == 10) d[0] = ~d[0];
      send_beat(d, b == 15);
    end
    wait_done("t3a_done");
    chk("t3a_err", 128'(err_cnt), 128'(1));
    chk("t3a_first", 128'(first_err_idx), 128'(10));

    // 3b: only bit 300 set on beat 3
    launch(64'h2000, 32'd1024, 32'd0, 32'd1);
    take_cmd("t3b_cmd", 64'h2000, 32'd1024, 0);
    for (int b = 0; b < 16; b++) begin
      d = pat(b, 32'd0);
      if (b == 3) d[300] = 1'b1;
      send_beat(d, b == 15);
    end
    wait_done("t3b_done");
`ifdef DMA_RD_FULL_CMP_EN
    exp_wide = 1;
`else
    exp_wide = 0;
`endif
    chk("t3b_err", 128'(err_cnt), 128'(exp_wide));

    // 4: early last on beat 2, missing last on beat 3
    launch(64'h3000, 32'd256, 32'd7, 32'd1);
    take_cmd("t4_cmd", 64'h3000, 32'd256, 0);
    send_beat(pat(0, 32'd7), 1'b0);
    send_beat(pat(1, 32'd7), 1'b0);
    send_beat(pat(2, 32'd7), 1'b1);
    chk("t4_still_busy", 128'({busy, done}), 128'(2'b10));
    send_beat(pat(3, 32'd7), 1'b0);
    chk("t4_done_now", 128'({busy, done}), 128'(2'b01));
    chk("t4_err", 128'(err_cnt), 128'(2));
    chk("t4_first", 128'(first_err_idx), 128'(2));
    chk("t4_beats", 128'(beat_cnt), 128'(4));

    // 5a: start re-toggled mid-run is ignored
    launch(64'h4000, 32'd256, 32'h55, 32'd1);
    take_cmd("t5a_cmd", 64'h4000, 32'd256, 0);
    send_beat(pat(0, 32'h55), 1'b0);
    send_beat(pat(1, 32'h55), 1'b0);
    start = 1'b1; tick(); tick(); start = 1'b0;
    send_beat(pat(2, 32'h55), 1'b0);
    send_beat(pat(3, 32'h55), 1'b1);
    wait_done("t5a_done");
    chk("t5a_beats", 128'({beat_cnt, err_cnt}), 128'({32'd4, 32'd0}));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); seen |= cmd_valid; end
    chk("t5a_no_relaunch", 128'(seen), 128'(0));

    // 5b: stray beats in IDLE
    do_reset();
    send_beat(pat(0, 32'd0), 1'b0);
    tick();
    send_beat(pat(1, 32'd0), 1'b1);
    chk("t5b_stray", 128'(stray_cnt), 128'(2));

    // 5c: illegal length
    launch(64'h5000, 32'd100, 32'd0, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); seen |= cmd_valid; end
    chk("t5c_flags", 128'({cfg_err, done, busy}), 128'(3'b110));
    chk("t5c_no_cmd", 128'(seen), 128'(0));
    chk("t5c_cnts", 128'({cycle_cnt, stray_cnt}), 128'(0));

    // 6: reset during DATA abandons the run
    launch(64'h6000, 32'd1024, 32'd0, 32'd2);
    take_cmd("t6_cmd", 64'h6000, 32'd1024, 0);
    for (int b = 0; b < 5; b++) send_beat(pat(b, 32'd0), 1'b0);
    chk("t6_mid_beats", 128'({busy, beat_cnt}), 128'({1'b1, 32'd5}));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("t6_cleared", 128'({busy, done, cmd_valid, beat_cnt, cycle_cnt, err_cnt}), 128'(0));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); seen |= cmd_valid; end
    chk("t6_no_cmd", 128'({seen, busy}), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
